vad_energy_gate: RTL and testbench

- Energy-based voice-activity detector in the VAD + gating path.
- Consumes the same 16-bit sample stream that is written into the circular pre-roll buffer.
- Measures per-frame energy and runs a hysteresis/hangover FSM.
- Outputs: a speech-active flag, start/end pulses that drive buffer readout control, and a gated copy of the live stream.

---
 rtl/vad_pkg.sv | 27 ++
 rtl/vad_frame_energy.sv | 83 ++++++++
 rtl/vad_energy_gate.sv | 224 ++++++++++++++++++++++
 tb/tb_vad_energy_gate.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vad_pkg.sv
// ---------------------------------------------------------------------------
// vad_pkg
// Shared types and constants for the energy-based voice-activity detector.
//   vad_state_t   : detector state (SILENCE, ONSET, SPEECH, HANGOVER)
//   DEF_*         : default values for the detector parameters
//   acc_width()   : energy accumulator width for a given frame length
// ---------------------------------------------------------------------------
package vad_pkg;

   typedef enum logic [1:0] {
      SILENCE  = 2'd0,
      ONSET    = 2'd1,
      SPEECH   = 2'd2,
      HANGOVER = 2'd3
   } vad_state_t;

   localparam int DEF_FRAME_LEN    = 256;
   localparam int DEF_ONSET_FRAMES = 2;
   localparam int DEF_HANG_FRAMES  = 8;

   // A frame of FRAME_LEN samples of at most 32768 each sums to at most
   // FRAME_LEN * 2^15, which needs exactly 16 + log2(FRAME_LEN) bits.
   function automatic int acc_width(input int frame_len);
      return 16 + $clog2(frame_len);
   endfunction

endpackage

// File: rtl/vad_frame_energy.sv
// ---------------------------------------------------------------------------
// vad_frame_energy
// Accumulates |x| over frames of FRAME_LEN valid samples and publishes the
// completed sum together with a one-cycle strobe.
//   clk, rst       : clock, asynchronous active-high reset
//   clear          : synchronous flush of the partial frame (detector disabled)
//   data_in        : signed 16-bit PCM sample
//   sample_valid   : data_in qualifier
//   frame_energy   : sum of |x| over the last completed frame
//   frame_done     : one-cycle pulse when frame_energy updates
// ---------------------------------------------------------------------------
module vad_frame_energy
   import vad_pkg::*;
#(
   parameter  int FRAME_LEN = DEF_FRAME_LEN,
   localparam int ACC_W     = acc_width(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [15:0]      data_in,
   input  logic             sample_valid,
   output logic [ACC_W-1:0] frame_energy,
   output logic             frame_done
);

   localparam int CNT_W = $clog2(FRAME_LEN);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [ACC_W-1:0] frame_energy_q, frame_energy_d;
   logic             frame_done_q, frame_done_d;

   logic [15:0]      abs_val;
   logic [ACC_W-1:0] sum;

   // Two's-complement negate kept at 16 bits unsigned so -32768 maps to 32768.
   assign abs_val = data_in[15] ? (~data_in + 16'd1) : data_in;
   assign sum     = acc_q + ACC_W'(abs_val);

   // On the last sample of a frame the running sum (including that sample)
   // is published and the accumulator restarts from zero, so a valid sample
   // in the very next cycle already belongs to the following frame.
   always_comb begin
      acc_d          = acc_q;
      sample_cnt_d   = sample_cnt_q;
      frame_energy_d = frame_energy_q;
      frame_done_d   = 1'b0;
      if (clear) begin
         acc_d        = '0;
         sample_cnt_d = '0;
      end else if (sample_valid) begin
         if (sample_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            frame_energy_d = sum;
            frame_done_d   = 1'b1;
            acc_d          = '0;
            sample_cnt_d   = '0;
         end else begin
            acc_d        = sum;
            sample_cnt_d = sample_cnt_q + 1'b1;
         end
      end
   end

   // Accumulator, sample counter and published frame registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q          <= '0;
         sample_cnt_q   <= '0;
         frame_energy_q <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         acc_q          <= acc_d;
         sample_cnt_q   <= sample_cnt_d;
         frame_energy_q <= frame_energy_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign frame_energy = frame_energy_q;
   assign frame_done   = frame_done_q;

endmodule

// File: rtl/vad_energy_gate.sv
// ---------------------------------------------------------------------------
// vad_energy_gate
// Energy-based voice-activity detector with onset/hangover hysteresis and a
// gated copy of the live sample stream.
//   clk, rst       : clock, asynchronous active-high reset
//   data_in        : signed 16-bit PCM sample
//   sample_valid   : data_in qualifier
//   vad_enable     : 0 forces SILENCE and flushes the partial frame
//   on_thresh      : onset energy threshold (unsigned)
//   off_thresh     : release energy threshold (unsigned)
//   frame_energy   : sum of |x| over the last completed frame
//   frame_done     : one-cycle pulse when frame_energy updates
//   vad_active     : high in SPEECH or HANGOVER
//   speech_start   : one-cycle pulse on entry to SPEECH from SILENCE/ONSET
//   speech_end     : one-cycle pulse on entry to SILENCE from SPEECH/HANGOVER
//   data_out       : registered copy of data_in
//   out_valid      : delayed sample_valid gated by vad_active
// Optional (macro VAD_STATS_EN):
//   segment_count  : saturating count of speech_start pulses
//   active_frames  : saturating count of frames completed while active
// ---------------------------------------------------------------------------
module vad_energy_gate
   import vad_pkg::*;
#(
   parameter  int FRAME_LEN    = DEF_FRAME_LEN,
   parameter  int ONSET_FRAMES = DEF_ONSET_FRAMES,
   parameter  int HANG_FRAMES  = DEF_HANG_FRAMES,
   localparam int ACC_W        = acc_width(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      data_in,
   input  logic             sample_valid,
   input  logic             vad_enable,
   input  logic [ACC_W-1:0] on_thresh,
   input  logic [ACC_W-1:0] off_thresh,
   output logic [ACC_W-1:0] frame_energy,
   output logic             frame_done,
   output logic             vad_active,
   output logic             speech_start,
   output logic             speech_end,
   output logic [15:0]      data_out,
   output logic             out_valid
`ifdef VAD_STATS_EN
  ,output logic [15:0]      segment_count,
   output logic [23:0]      active_frames
`endif
);

   localparam int MAX_FR = (ONSET_FRAMES > HANG_FRAMES) ? ONSET_FRAMES : HANG_FRAMES;
   localparam int CNT_W  = $clog2(MAX_FR + 2);

   vad_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             start_q, start_d;
   logic             end_q, end_d;
   logic [15:0]      data_out_q, data_out_d;
   logic             valid_dly_q;

   // ------------------------------------------------------------------------
   // Frame energy measurement
   // ------------------------------------------------------------------------
   vad_frame_energy #(
      .FRAME_LEN   (FRAME_LEN)
   ) u_frame_energy (
      .clk          (clk),
      .rst          (rst),
      .clear        (~vad_enable),
      .data_in      (data_in),
      .sample_valid (sample_valid),
      .frame_energy (frame_energy),
      .frame_done   (frame_done)
   );

   assign cnt_inc = cnt_q + 1'b1;

   // Hysteresis FSM, stepped once per completed frame. cnt counts consecutive
   // qualifying frames in ONSET (energy >= on) and HANGOVER (energy < off).
   // Disabling the detector overrides everything and emits an end pulse only
   // if speech was actually in progress.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      end_d   = 1'b0;
      if (!vad_enable) begin
         state_d = SILENCE;
         cnt_d   = '0;
         end_d   = (state_q == SPEECH) || (state_q == HANGOVER);
      end else if (frame_done) begin
         case (state_q)
            SILENCE: begin
               if (frame_energy >= on_thresh) begin
                  if (ONSET_FRAMES <= 1) begin
                     state_d = SPEECH;
                     cnt_d   = '0;
                     start_d = 1'b1;
                  end else begin
                     state_d = ONSET;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            ONSET: begin
               if (frame_energy >= on_thresh) begin
                  if (cnt_inc >= CNT_W'(ONSET_FRAMES)) begin
                     state_d = SPEECH;
                     cnt_d   = '0;
                     start_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = SILENCE;
                  cnt_d   = '0;
               end
            end
            SPEECH: begin
               if (frame_energy < off_thresh) begin
                  if (HANG_FRAMES == 0) begin
                     state_d = SILENCE;
                     cnt_d   = '0;
                     end_d   = 1'b1;
                  end else begin
                     state_d = HANGOVER;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            HANGOVER: begin
               // Recovering speech goes straight back to SPEECH without a pulse.
               if (frame_energy >= off_thresh) begin
                  state_d = SPEECH;
                  cnt_d   = '0;
               end else if (cnt_inc >= CNT_W'(HANG_FRAMES)) begin
                  state_d = SILENCE;
                  cnt_d   = '0;
                  end_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = SILENCE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // FSM state, counter and registered start/end pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SILENCE;
         cnt_q   <= '0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         end_q   <= end_d;
      end
   end

   // Sample copy is only refreshed on valid samples so data_out holds the
   // last real sample between them.
   always_comb begin
      data_out_d = data_out_q;
      if (sample_valid) begin
         data_out_d = data_in;
      end
   end

   // Output data path registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_q  <= '0;
         valid_dly_q <= 1'b0;
      end else begin
         data_out_q  <= data_out_d;
         valid_dly_q <= sample_valid;
      end
   end

   assign vad_active   = (state_q == SPEECH) || (state_q == HANGOVER);
   assign speech_start = start_q;
   assign speech_end   = end_q;
   assign data_out     = data_out_q;
   assign out_valid    = valid_dly_q & vad_active;

`ifdef VAD_STATS_EN
   logic [15:0] seg_cnt_q, seg_cnt_d;
   logic [23:0] act_frm_q, act_frm_d;

   // Saturating statistics counters.
   always_comb begin
      seg_cnt_d = seg_cnt_q;
      act_frm_d = act_frm_q;
      if (start_q && (seg_cnt_q != 16'hFFFF)) begin
         seg_cnt_d = seg_cnt_q + 16'd1;
      end
      if (frame_done && vad_active && (act_frm_q != 24'hFF_FFFF)) begin
         act_frm_d = act_frm_q + 24'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_cnt_q <= '0;
         act_frm_q <= '0;
      end else begin
         seg_cnt_q <= seg_cnt_d;
         act_frm_q <= act_frm_d;
      end
   end

   assign segment_count = seg_cnt_q;
   assign active_frames = act_frm_q;
`endif

endmodule

// File: tb/tb_vad_energy_gate.sv
// ---------------------------------------------------------------------------
// tb_vad_energy_gate
// Drives vad_energy_gate with frames of randomized samples and compares every
// output each cycle against a frame-level behavioural model of the detector.
// ---------------------------------------------------------------------------
module tb_vad_energy_gate;

   localparam int FRAME_LEN    = 256;
   localparam int ONSET_FRAMES = 2;
   localparam int HANG_FRAMES  = 8;
   localparam int ACC_W        = 16 + $clog2(FRAME_LEN);
   localparam int ON_TH        = 100000;
   localparam int OFF_TH       = 50000;

   logic             clk = 1'b0;
   logic             rst;
   logic [15:0]      data_in;
   logic             sample_valid;
   logic             vad_enable;
   logic [ACC_W-1:0] on_thresh;
   logic [ACC_W-1:0] off_thresh;
   logic [ACC_W-1:0] frame_energy;
   logic             frame_done;
   logic             vad_active;
   logic             speech_start;
   logic             speech_end;
   logic [15:0]      data_out;
   logic             out_valid;

   int checkCount = 0;
   int errorCount = 0;
   bit randomDrops = 0;

   // Reference model: running frame sum, last published frame, and a
   // speech flag with run-length counters for onset and release.
   longint mSum;
   int     mSamples;
   longint mEnergy;
   bit     mDone;
   bit     mSpeech;
   int     onRun;
   int     lowRun;
   bit     mStart;
   bit     mEnd;
   logic [15:0] mData;
   bit     mValidD;

   vad_energy_gate #(
      .FRAME_LEN    (FRAME_LEN),
      .ONSET_FRAMES (ONSET_FRAMES),
      .HANG_FRAMES  (HANG_FRAMES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .sample_valid (sample_valid),
      .vad_enable   (vad_enable),
      .on_thresh    (on_thresh),
      .off_thresh   (off_thresh),
      .frame_energy (frame_energy),
      .frame_done   (frame_done),
      .vad_active   (vad_active),
      .speech_start (speech_start),
      .speech_end   (speech_end),
      .data_out     (data_out),
      .out_valid    (out_valid)
   );

   // Free-running 10 time-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic void modelReset();
      mSum = 0; mSamples = 0; mEnergy = 0; mDone = 0;
      mSpeech = 0; onRun = 0; lowRun = 0;
      mStart = 0; mEnd = 0; mData = '0; mValidD = 0;
   endfunction

   // One clock edge of the reference model. The detector decision uses the
   // frame published by the previous edge, so it lands one cycle after it.
   function automatic void modelStep(input bit v, input logic [15:0] d, input bit en);
      int x;
      bit newDone;
      mStart = 0;
      mEnd   = 0;
      if (!en) begin
         if (mSpeech) mEnd = 1;
         mSpeech = 0; onRun = 0; lowRun = 0;
      end else if (mDone) begin
         if (!mSpeech) begin
            onRun = (mEnergy >= ON_TH) ? onRun + 1 : 0;
            if (onRun >= ONSET_FRAMES) begin
               mSpeech = 1; mStart = 1; onRun = 0; lowRun = 0;
            end
         end else begin
            lowRun = (mEnergy < OFF_TH) ? lowRun + 1 : 0;
            if (lowRun >= HANG_FRAMES && lowRun > 0) begin
               mSpeech = 0; mEnd = 1; lowRun = 0; onRun = 0;
            end
         end
      end
      newDone = 0;
      if (!en) begin
         mSum = 0; mSamples = 0;
      end else if (v) begin
         x = int'($signed(d));
         mSum += (x < 0) ? -x : x;
         mSamples++;
         if (mSamples == FRAME_LEN) begin
            mEnergy = mSum; newDone = 1; mSum = 0; mSamples = 0;
         end
      end
      mDone = newDone;
      if (v) mData = d;
      mValidD = v;
   endfunction

   task automatic checkAll();
      checkOutput("frame_energy", frame_energy, mEnergy);
      checkOutput("frame_done",   frame_done,   mDone);
      checkOutput("vad_active",   vad_active,   mSpeech);
      checkOutput("speech_start", speech_start, mStart);
      checkOutput("speech_end",   speech_end,   mEnd);
      checkOutput("data_out",     data_out,     mData);
      checkOutput("out_valid",    out_valid,    mValidD & mSpeech);
      checkOutput("pulse_excl",   speech_start & speech_end, 0);
   endtask

   // Drive one cycle of inputs, advance the model on the edge, check at negedge.
   task automatic applyStimulus(input bit v, input logic [15:0] d, input bit en);
      sample_valid = v;
      data_in      = d;
      vad_enable   = en;
      @(posedge clk);
      modelStep(v, d, en);
      @(negedge clk);
      checkAll();
   endtask

   // One frame of valid samples with random idle gaps.
   // mode 0: alternating +amp/-amp, 1: constant amp, 2: random magnitude <= amp.
   task automatic sendFrame(input int mode, input int amp);
      int val;
      bit en;
      for (int n = 0; n < FRAME_LEN; n++) begin
         while ($urandom_range(3) == 0) applyStimulus(1'b0, 16'($urandom), 1'b1);
         case (mode)
            0:       val = (n % 2 == 1) ? -amp : amp;
            1:       val = amp;
            default: begin
               val = int'($urandom_range(amp));
               if ($urandom_range(1) == 1) val = -val;
            end
         endcase
         en = !(randomDrops && $urandom_range(1999) == 0);
         applyStimulus(1'b1, 16'(val), en);
      end
   endtask

   initial begin
      int amps[6];
      amps = '{0, 150, 300, 400, 1000, 32767};

      rst          = 1'b1;
      data_in      = '0;
      sample_valid = 1'b0;
      vad_enable   = 1'b1;
      on_thresh    = ACC_W'(ON_TH);
      off_thresh   = ACC_W'(OFF_TH);
      modelReset();
      repeat (2) @(negedge clk);
      checkAll();
      rst = 1'b0;
      $display("[TB] reset released");

      // Reset in the middle of a frame discards the partial sum.
      for (int i = 0; i < 100; i++) applyStimulus(1'b1, 16'(3000), 1'b1);
      sample_valid = 1'b1;
      data_in      = 16'(5000);
      rst          = 1'b1;
      modelReset();
      #1;
      checkAll();
      repeat (3) begin
         @(negedge clk);
         checkAll();
      end
      rst = 1'b0;
      sendFrame(1, 100);
      checkOutput("post_reset_energy", frame_energy, 25600);

      // Rejected onset: one loud frame followed by silence.
      $display("[TB] rejected onset");
      sendFrame(1, 1000);
      checkOutput("reject_energy", frame_energy, 256000);
      sendFrame(1, 0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("reject_inactive", vad_active, 0);

      // Onset over two alternating frames.
      $display("[TB] onset");
      sendFrame(0, 1000);
      checkOutput("onset_energy1", frame_energy, 256000);
      sendFrame(0, 1000);
      checkOutput("onset_energy2", frame_energy, 256000);
      checkOutput("onset_pre_valid", out_valid, 0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("onset_start", speech_start, 1);
      checkOutput("onset_active", vad_active, 1);

      // Hangover recovery: three silent frames then a mid-level frame.
      $display("[TB] hangover recovery");
      repeat (3) sendFrame(1, 0);
      sendFrame(0, 300);
      checkOutput("recover_energy", frame_energy, 76800);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("recover_active", vad_active, 1);

      // Release after the full hangover.
      $display("[TB] release");
      repeat (HANG_FRAMES) sendFrame(1, 0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("release_end", speech_end, 1);
      checkOutput("release_inactive", vad_active, 0);

      // Width edge: full-scale negative frame.
      $display("[TB] width edge");
      sendFrame(1, -32768);
      checkOutput("max_energy", frame_energy, 8388608);
      sendFrame(1, 0);
      checkOutput("zero_energy", frame_energy, 0);

      // Disabling during speech forces SILENCE with an end pulse.
      $display("[TB] enable drop");
      repeat (2) sendFrame(0, 1000);
      for (int i = 0; i < 50; i++) applyStimulus(1'b1, 16'($urandom), 1'b1);
      applyStimulus(1'b1, 16'(1234), 1'b0);
      checkOutput("disable_end", speech_end, 1);
      checkOutput("disable_inactive", vad_active, 0);
      applyStimulus(1'b0, '0, 1'b0);
      sendFrame(1, 200);
      checkOutput("after_disable_energy", frame_energy, 51200);

      // Randomized frames with occasional enable drops.
      $display("[TB] random frames");
      randomDrops = 1;
      for (int f = 0; f < 30; f++) begin
         sendFrame(int'($urandom_range(2)), amps[$urandom_range(5)]);
      end
      randomDrops = 0;
      repeat (5) applyStimulus(1'b0, '0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
